alu_cmd_driver: RTL and testbench

//  Initiator for the team's registered 8-bit ALU (add/sub/mul, 16-bit result).
//  - Accepts one operation per command over a valid/ready handshake.
//  - Drives the ALU operand, enable and select pins, waits out the ALU pipeline,

---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu_cmd_driver.sv | 139 +++++++++++++
 tb/tb_alu_cmd_driver.sv | 358 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command driver: op codes, FSM states and
// the op-code legality check.
package alu_pkg;

    localparam logic [2:0] ADD_MODE = 3'b000;
    localparam logic [2:0] SUB_MODE = 3'b001;
    localparam logic [2:0] MUL_MODE = 3'b010;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } alu_drv_state_t;

    // True for the op codes the ALU implements.
    function automatic logic is_supported_op(input logic [2:0] op);
        return (op == ADD_MODE) || (op == SUB_MODE) || (op == MUL_MODE);
    endfunction

endpackage

// File: rtl/alu_cmd_driver.sv
// Command initiator for the registered 8-bit ALU. Accepts one operation per
// command handshake, loads the ALU operand registers, waits out the ALU
// pipeline, captures the result and returns it over a response handshake.
// Unsupported op codes are answered directly with err=1, data=0.
module alu_cmd_driver
    import alu_pkg::*;
#(
    parameter int ALU_LAT = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [7:0]  cmd_a_i,
    input  logic [7:0]  cmd_b_i,
    input  logic [2:0]  cmd_op_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [15:0] rsp_data_o,
    output logic        rsp_err_o,
    output logic [7:0]  alu_data_o [1:0],
    output logic [2:0]  alu_sel_o,
    output logic        alu_ea_o,
    output logic        alu_eb_o,
    input  logic [15:0] alu_p_i
);

    localparam int CW = $clog2(ALU_LAT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(ALU_LAT - 1);

    alu_drv_state_t state_reg, state_next;
    logic [7:0]     a_reg, a_next;
    logic [7:0]     b_reg, b_next;
    logic [2:0]     op_reg, op_next;
    logic [CW-1:0]  cnt_reg, cnt_next;
    logic [15:0]    data_reg, data_next;
    logic           err_reg, err_next;

    // State and datapath registers; reset drops any in-flight operation.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            op_reg    <= '0;
            cnt_reg   <= '0;
            data_reg  <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            op_reg    <= op_next;
            cnt_reg   <= cnt_next;
            data_reg  <= data_next;
            err_reg   <= err_next;
        end
    end

    // Next-state logic: accept, issue, count out the ALU latency, respond.
    always_comb begin
        state_next = state_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        op_next    = op_reg;
        cnt_next   = cnt_reg;
        data_next  = data_reg;
        err_next   = err_reg;
        case (state_reg)
            IDLE: begin
                if (cmd_valid_i) begin
                    a_next   = cmd_a_i;
                    b_next   = cmd_b_i;
                    op_next  = cmd_op_i;
                    cnt_next = '0;
                    if (is_supported_op(cmd_op_i)) begin
                        state_next = ISSUE;
                    end else begin
                        // Answered without touching the ALU.
                        data_next  = '0;
                        err_next   = 1'b1;
                        state_next = RESP;
                    end
                end
            end
            ISSUE: begin
                cnt_next   = '0;
                state_next = WAIT;
            end
            WAIT: begin
                if (cnt_reg == CNT_LAST) begin
                    data_next  = alu_p_i;
                    err_next   = 1'b0;
                    state_next = RESP;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output decode from the current state; ALU pins are quiet in IDLE.
    always_comb begin
        cmd_ready_o   = 1'b0;
        rsp_valid_o   = 1'b0;
        alu_data_o[0] = '0;
        alu_data_o[1] = '0;
        alu_sel_o     = '0;
        alu_ea_o      = 1'b0;
        alu_eb_o      = 1'b0;
        case (state_reg)
            IDLE: cmd_ready_o = 1'b1;
            ISSUE: begin
                alu_data_o[0] = a_reg;
                alu_data_o[1] = b_reg;
                alu_sel_o     = op_reg;
                alu_ea_o      = 1'b1;
                alu_eb_o      = 1'b1;
            end
            WAIT: alu_sel_o = op_reg;
            RESP: begin
                rsp_valid_o = 1'b1;
                // An unsupported op never reaches the ALU, so sel stays 0.
                alu_sel_o   = err_reg ? 3'b000 : op_reg;
            end
            default: cmd_ready_o = 1'b0;
        endcase
    end

    assign rsp_data_o = data_reg;
    assign rsp_err_o  = err_reg;

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Randomised scoreboard bench for alu_cmd_driver paired with a behavioural
// registered ALU. A second instance built with ALU_LAT=3 checks latency scaling.
module tb_alu_cmd_driver;
    import alu_pkg::*;

    localparam int LAT = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        cmd_valid, cmd_ready;
    logic [7:0]  cmd_a, cmd_b;
    logic [2:0]  cmd_op;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [15:0] rsp_data;
    logic [7:0]  alu_data [1:0];
    logic [2:0]  alu_sel;
    logic        alu_ea, alu_eb;
    logic [15:0] alu_p = '0;

    logic        man_ready, rand_ready, rnd_bit;
    assign rsp_ready = rand_ready ? rnd_bit : man_ready;

    alu_cmd_driver #(.ALU_LAT(LAT)) dut (
        .clk_i(clk), .rst_i(rst),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
        .cmd_a_i(cmd_a), .cmd_b_i(cmd_b), .cmd_op_i(cmd_op),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_data_o(rsp_data), .rsp_err_o(rsp_err),
        .alu_data_o(alu_data), .alu_sel_o(alu_sel),
        .alu_ea_o(alu_ea), .alu_eb_o(alu_eb), .alu_p_i(alu_p)
    );

    // Second instance with a three-cycle ALU.
    logic        c3_valid, c3_ready, c3_rsp_valid, c3_rsp_err;
    logic [7:0]  c3_a, c3_b;
    logic [2:0]  c3_op;
    logic [15:0] c3_rsp_data;
    logic [7:0]  c3_alu_data [1:0];
    logic [2:0]  c3_sel;
    logic        c3_ea, c3_eb;
    logic [15:0] c3_p = '0;

    alu_cmd_driver #(.ALU_LAT(3)) dut3 (
        .clk_i(clk), .rst_i(rst),
        .cmd_valid_i(c3_valid), .cmd_ready_o(c3_ready),
        .cmd_a_i(c3_a), .cmd_b_i(c3_b), .cmd_op_i(c3_op),
        .rsp_valid_o(c3_rsp_valid), .rsp_ready_i(1'b1),
        .rsp_data_o(c3_rsp_data), .rsp_err_o(c3_rsp_err),
        .alu_data_o(c3_alu_data), .alu_sel_o(c3_sel),
        .alu_ea_o(c3_ea), .alu_eb_o(c3_eb), .alu_p_i(c3_p)
    );

    // Behavioural registered ALU: operand registers, then LAT-1 result stages.
    function automatic logic [15:0] alu_calc(input logic [2:0] sel, input logic [7:0] a, input logic [7:0] b);
        case (sel)
            3'b000:  return {8'h00, a} + {8'h00, b};
            3'b001:  return {8'h00, a} - {8'h00, b};
            3'b010:  return 16'(a) * 16'(b);
            default: return 16'h0000;
        endcase
    endfunction

    logic [7:0]  alu_a = '0, alu_b = '0, a3 = '0, b3 = '0;
    logic [15:0] p3a = '0;

    always @(posedge clk) begin
        if (alu_ea) alu_a <= alu_data[0];
        if (alu_eb) alu_b <= alu_data[1];
        alu_p <= alu_calc(alu_sel, alu_a, alu_b);
    end

    always @(posedge clk) begin
        if (c3_ea) a3 <= c3_alu_data[0];
        if (c3_eb) b3 <= c3_alu_data[1];
        p3a  <= alu_calc(c3_sel, a3, b3);
        c3_p <= p3a;
    end

    // Reference model: integer arithmetic on the operand values.
    task automatic ref_model(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                             output logic [15:0] data, output logic err);
        int ia, ib;
        ia = int'(a);
        ib = int'(b);
        err = 1'b0;
        if (op == ADD_MODE)      data = 16'(ia + ib);
        else if (op == SUB_MODE) data = 16'(ia - ib + 65536);
        else if (op == MUL_MODE) data = 16'(ia * ib);
        else begin
            data = 16'h0000;
            err  = 1'b1;
        end
    endtask

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [2:0]  op;
        logic [15:0] data;
        logic        err;
        int          acc_cyc;
    } exp_t;

    exp_t sbq[$];
    int   cyc = 0;

    // Random response back-pressure.
    initial begin
        rnd_bit = 1'b1;
        forever begin
            @(posedge clk);
            #1 rnd_bit = 1'($urandom_range(0, 1));
        end
    end

    // Monitor: scores responses, latency, stall stability and ALU issue.
    initial begin : monitor
        logic        prev_valid;
        logic [15:0] prev_data;
        logic        prev_err;
        exp_t        e;
        prev_valid = 1'b0;
        prev_data  = '0;
        prev_err   = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_valid = 1'b0;
            end else begin
                cyc++;
                if (rsp_valid) begin
                    check("cmd_ready_during_rsp", 32'(cmd_ready), 32'd0);
                    if (prev_valid) begin
                        check("stall_data_stable", 32'(rsp_data), 32'(prev_data));
                        check("stall_err_stable", 32'(rsp_err), 32'(prev_err));
                    end else if (sbq.size() == 0) begin
                        fail_now("unexpected_rsp");
                    end else begin
                        check("latency", 32'(cyc - sbq[0].acc_cyc),
                              sbq[0].err ? 32'd1 : 32'(2 + LAT));
                    end
                    if (rsp_ready && sbq.size() > 0) begin
                        e = sbq.pop_front();
                        check("rsp_data", 32'(rsp_data), 32'(e.data));
                        check("rsp_err", 32'(rsp_err), 32'(e.err));
                        $display("txn op=%0d a=0x%02h b=0x%02h data=0x%04h err=%0b exp=0x%04h/%0b",
                                 e.op, e.a, e.b, rsp_data, rsp_err, e.data, e.err);
                    end
                end
                if (alu_ea || alu_eb) begin
                    if (sbq.size() == 0) begin
                        fail_now("alu_issue_without_cmd");
                    end else begin
                        check("issue_ea", 32'(alu_ea), 32'd1);
                        check("issue_eb", 32'(alu_eb), 32'd1);
                        check("issue_supported", 32'(sbq[0].err), 32'd0);
                        check("issue_sel", 32'(alu_sel), 32'(sbq[0].op));
                        check("issue_data", {16'h0, alu_data[1], alu_data[0]},
                              {16'h0, sbq[0].b, sbq[0].a});
                    end
                end
                if (cmd_ready) begin
                    check("idle_sel_zero", 32'(alu_sel), 32'd0);
                end
                if (cmd_valid && cmd_ready) begin
                    e.a  = cmd_a;
                    e.b  = cmd_b;
                    e.op = cmd_op;
                    ref_model(cmd_a, cmd_b, cmd_op, e.data, e.err);
                    e.acc_cyc = cyc;
                    sbq.push_back(e);
                end
                prev_valid = rsp_valid && !rsp_ready;
                prev_data  = rsp_data;
                prev_err   = rsp_err;
            end
        end
    end

    // Present a command and hold it until accepted; optionally leave valid high.
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op, input bit hold);
        int n;
        n = 0;
        cmd_a = a;
        cmd_b = b;
        cmd_op = op;
        cmd_valid = 1'b1;
        @(negedge clk);
        while (!cmd_ready && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) fail_now("cmd_accept_timeout");
        @(posedge clk);
        #1;
        if (!hold) cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((sbq.size() != 0 || !cmd_ready) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sbq.size() != 0 || !cmd_ready) fail_now("drain_timeout");
        @(posedge clk);
        #1;
    endtask

    task automatic run3(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        int n;
        logic [15:0] ed;
        logic        ee;
        ref_model(a, b, op, ed, ee);
        c3_a = a;
        c3_b = b;
        c3_op = op;
        c3_valid = 1'b1;
        @(negedge clk);
        check("lat3_ready", 32'(c3_ready), 32'd1);
        @(posedge clk);
        #1 c3_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!c3_rsp_valid && n < 30);
        check("lat3_latency", 32'(n), ee ? 32'd1 : 32'd5);
        check("lat3_data", 32'(c3_rsp_data), 32'(ed));
        check("lat3_err", 32'(c3_rsp_err), 32'(ee));
        $display("txn lat3 op=%0d a=0x%02h b=0x%02h data=0x%04h cycles=%0d", op, a, b, c3_rsp_data, n);
        @(posedge clk);
        #1;
    endtask

    initial begin : main
        int n;
        logic [2:0] op;
        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_a = '0;
        cmd_b = '0;
        cmd_op = '0;
        man_ready = 1'b1;
        rand_ready = 1'b0;
        c3_valid = 1'b0;
        c3_a = '0;
        c3_b = '0;
        c3_op = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_cmd_ready", 32'(cmd_ready), 32'd1);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rsp_data", 32'(rsp_data), 32'd0);
        check("reset_rsp_err", 32'(rsp_err), 32'd0);
        check("reset_alu_en", {30'd0, alu_ea, alu_eb}, 32'd0);
        check("reset_alu_sel", 32'(alu_sel), 32'd0);
        check("reset_alu_data", {16'h0, alu_data[1], alu_data[0]}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Basic add.
        send(8'h12, 8'h34, ADD_MODE, 1'b0);
        wait_idle();

        // Back-to-back with valid held high.
        send(8'h03, 8'h05, SUB_MODE, 1'b1);
        send(8'hFF, 8'hFF, MUL_MODE, 1'b0);
        wait_idle();

        // Unsupported op.
        send(8'h01, 8'h01, 3'b111, 1'b0);
        wait_idle();

        // Response stall with the next command already waiting.
        man_ready = 1'b0;
        send(8'h10, 8'h10, MUL_MODE, 1'b1);
        cmd_a = 8'h05;
        cmd_b = 8'h06;
        cmd_op = ADD_MODE;
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!rsp_valid) fail_now("stall_rsp_timeout");
        repeat (5) @(posedge clk);
        #1 man_ready = 1'b1;
        send(8'h05, 8'h06, ADD_MODE, 1'b0);
        wait_idle();

        // Asynchronous reset in the middle of WAIT.
        send(8'h40, 8'h22, ADD_MODE, 1'b0);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("midrst_rsp_data", 32'(rsp_data), 32'd0);
        check("midrst_alu_sel", 32'(alu_sel), 32'd0);
        check("midrst_alu_en", {30'd0, alu_ea, alu_eb}, 32'd0);
        sbq.delete();
        @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        send(8'h01, 8'h01, ADD_MODE, 1'b0);
        wait_idle();

        // Random traffic with random back-pressure.
        rand_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            op = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            send(8'($urandom), 8'($urandom), op, 1'($urandom_range(0, 1)));
        end
        cmd_valid = 1'b0;
        rand_ready = 1'b0;
        wait_idle();

        // Three-cycle ALU build.
        run3(8'h80, 8'h80, ADD_MODE);
        run3(8'h07, 8'h09, SUB_MODE);
        run3(8'hC3, 8'h5A, MUL_MODE);
        run3(8'h02, 8'h02, 3'b101);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global guard against a hung run.
    initial begin
        #200000;
        $display("FAIL global_timeout at %0t", $time);
        $fatal(1, "timeout");
    end

endmodule
